// File: rtl/mtx_frame_scheduler.sv
// Manchester frame scheduler feeding the OSER8 parallel word path.
// Frame sequence: preamble, SFD, streamed payload, ETD, then the inter-frame gap.
// Link pulses (NLP_WORD) are sent periodically while the line is idle.
// ser_word[7] is the first half-bit on the wire. Every output is registered and
// shows the word for a state slot one cycle after the FSM enters that slot.
module mtx_frame_scheduler #(
  parameter int unsigned PRE_BYTES  = 7,
  parameter logic [7:0]  PRE_BYTE   = 8'hAA,
  parameter logic [7:0]  SFD_BYTE   = 8'hD5,
  parameter int unsigned IFG_WORDS  = 24,
  parameter int unsigned NLP_PERIOD = 432000,
  parameter logic [7:0]  NLP_WORD   = 8'hC0
) (
  input  logic       pclk,
  input  logic       aresetn,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] ser_word,
  output logic       line_active,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned IFG_W = $clog2(IFG_WORDS + 1);
  localparam int unsigned NLP_W = $clog2(NLP_PERIOD);

  localparam logic [3:0]       PRE_LAST = 4'(PRE_BYTES - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_WORDS - 1);
  localparam logic [NLP_W-1:0] NLP_LAST = NLP_W'(NLP_PERIOD - 1);
  localparam logic [7:0]       ETD_WORD = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_ETD  = 3'd4,
    ST_IFG  = 3'd5
  } state_t;

  state_t           state;
  logic             half;
  logic [3:0]       byte_cnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic [NLP_W-1:0] nlp_cnt;
  logic [7:0]       hold_byte;
  logic             hold_last;
  logic             aborted;

  // One half of a byte in Manchester form: each bit b becomes {~b, b}, MSB first.
  function automatic logic [7:0] man_word(input logic [7:0] b, input logic h);
    logic [3:0] nib;
    logic [7:0] w;
    w   = '0;
    nib = h ? b[3:0] : b[7:4];
    for (int j = 0; j < 4; j++) begin
      w[2*j+1] = ~nib[j];
      w[2*j]   = nib[j];
    end
    return w;
  endfunction

  // Frame sequencer: state, counters, payload holding register and all outputs.
  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      half        <= 1'b0;
      byte_cnt    <= '0;
      ifg_cnt     <= '0;
      nlp_cnt     <= '0;
      hold_byte   <= '0;
      hold_last   <= 1'b0;
      aborted     <= 1'b0;
      s_tready    <= 1'b0;
      ser_word    <= '0;
      line_active <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      s_tready    <= 1'b0;
      ser_word    <= '0;
      line_active <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      busy        <= (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (nlp_cnt == NLP_LAST) begin
            ser_word <= NLP_WORD;
            nlp_cnt  <= '0;
          end else begin
            nlp_cnt <= nlp_cnt + NLP_W'(1);
          end
          // A waiting byte only starts the frame; it is taken later in SFD.
          if (s_tvalid) begin
            state    <= ST_PRE;
            half     <= 1'b0;
            byte_cnt <= '0;
            nlp_cnt  <= '0;
            aborted  <= 1'b0;
          end
        end

        ST_PRE: begin
          ser_word    <= man_word(PRE_BYTE, half);
          line_active <= 1'b1;
          half        <= ~half;
          if (half) begin
            if (byte_cnt == PRE_LAST) begin
              state <= ST_SFD;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end

        ST_SFD, ST_DATA: begin
          ser_word    <= man_word((state == ST_SFD) ? SFD_BYTE : hold_byte, half);
          line_active <= 1'b1;
          half        <= ~half;
          if (!half) begin
            // Ready is raised for the second half of every byte that is not the last.
            s_tready <= (state == ST_SFD) || !hold_last;
          end else if ((state == ST_DATA) && hold_last) begin
            state <= ST_ETD;
          end else if (s_tvalid) begin
            hold_byte <= s_tdata;
            hold_last <= s_tlast;
            state     <= ST_DATA;
          end else begin
            // Source starved the line: close the frame with ETD and flag it.
            underrun <= 1'b1;
            aborted  <= 1'b1;
            state    <= ST_ETD;
          end
        end

        ST_ETD: begin
          ser_word    <= ETD_WORD;
          line_active <= 1'b1;
          half        <= ~half;
          if (half) begin
            state      <= ST_IFG;
            ifg_cnt    <= '0;
            frame_done <= !aborted;
          end
        end

        ST_IFG: begin
          ifg_cnt <= ifg_cnt + IFG_W'(1);
          if (ifg_cnt == IFG_LAST) begin
            // A source already waiting at gap end goes straight to preamble so
            // back-to-back frames are spaced by ETD plus exactly IFG_WORDS words.
            if (s_tvalid) begin
              state    <= ST_PRE;
              half     <= 1'b0;
              byte_cnt <= '0;
              aborted  <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtx_frame_scheduler.sv
// Scoreboard bench for mtx_frame_scheduler: a driver pushes the expected line
// words and frame events per frame; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mtx_frame_scheduler;

  localparam int       PRE_BYTES  = 2;
  localparam logic [7:0] PRE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int       IFG_WORDS  = 6;
  localparam int       NLP_PERIOD = 40;
  localparam logic [7:0] NLP_WORD = 8'hC0;

  logic       pclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] ser_word;
  logic       line_active;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  always #5 pclk = ~pclk;

  mtx_frame_scheduler #(
    .PRE_BYTES (PRE_BYTES),
    .PRE_BYTE  (PRE_BYTE),
    .SFD_BYTE  (SFD_BYTE),
    .IFG_WORDS (IFG_WORDS),
    .NLP_PERIOD(NLP_PERIOD),
    .NLP_WORD  (NLP_WORD)
  ) dut (
    .pclk       (pclk),
    .aresetn    (aresetn),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .ser_word   (ser_word),
    .line_active(line_active),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_words[$];
  int         exp_evt[$];   // 0 = frame_done, 1 = underrun
  int         exp_gap[$];   // 1 = back-to-back (exact gap), 0 = at least the gap
  logic [7:0] frm[$];
  bit         chk_en = 1'b0;
  int         frames_since_reset = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference encoding: shift in two half-bits per payload bit, MSB first.
  function automatic logic [15:0] manchester(input logic [7:0] b);
    logic [15:0] m;
    m = '0;
    for (int i = 7; i >= 0; i--) m = {m[13:0], (b[i] ? 2'b01 : 2'b10)};
    return m;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    logic [15:0] m;
    m = manchester(b);
    exp_words.push_back(m[15:8]);
    exp_words.push_back(m[7:0]);
  endtask

  // Drive the bytes in frm; ab>0 drops s_tvalid after ab accepted bytes.
  task automatic send_frame(input int n, input int ab, input bit b2b);
    int  idx;
    int  cyc;
    int  limit;
    int  nacc;
    bit  done;
    nacc = (ab > 0) ? ab : n;
    for (int i = 0; i < PRE_BYTES; i++) push_byte(PRE_BYTE);
    push_byte(SFD_BYTE);
    for (int i = 0; i < nacc; i++) push_byte(frm[i]);
    exp_words.push_back(8'hFF);
    exp_words.push_back(8'hFF);
    exp_evt.push_back((ab > 0) ? 1 : 0);
    if (frames_since_reset > 0) exp_gap.push_back(b2b ? 1 : 0);
    frames_since_reset++;

    idx = 0;
    cyc = 0;
    done = 1'b0;
    limit = 8 * (PRE_BYTES + n + 4) + 2 * IFG_WORDS + 50;
    s_tdata  = frm[0];
    s_tlast  = (n == 1);
    s_tvalid = 1'b1;
    while (!done && cyc <= limit) begin
      @(negedge pclk);
      cyc++;
      if (s_tready) begin
        if (!s_tvalid) begin
          @(posedge pclk); #1;
          done = 1'b1;
        end else begin
          @(posedge pclk); #1;
          idx++;
          if (idx == n) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            done     = 1'b1;
          end else begin
            s_tdata = frm[idx];
            s_tlast = (idx == n - 1);
            if (ab > 0 && idx == ab) s_tvalid = 1'b0;
          end
        end
      end
    end
    check("send_done", done, cyc, limit);
    if (!done) begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge pclk);
    #1;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_words.size() != 0 || exp_evt.size() != 0) && cyc < 1000) begin
      @(posedge pclk);
      cyc++;
    end
    @(negedge pclk); #1;
    check("drain_words", exp_words.size() == 0, exp_words.size(), 0);
    check("drain_events", exp_evt.size() == 0, exp_evt.size(), 0);
  endtask

  // Monitor: compares every active word, gap spacing, IFG zeros and pulses.
  initial begin : monitor
    bit         prev_la;
    bit         seen_frame;
    int         low_run;
    logic [7:0] w;
    int         g;
    int         e;
    prev_la = 1'b0;
    seen_frame = 1'b0;
    low_run = 0;
    forever begin
      @(negedge pclk);
      if (!aresetn || !chk_en) begin
        prev_la = 1'b0;
        seen_frame = 1'b0;
        low_run = 0;
      end else begin
        if (line_active) begin
          if (!prev_la && seen_frame) begin
            if (exp_gap.size() == 0) check("gap_unexpected", 1'b0, low_run, 0);
            else begin
              g = exp_gap.pop_front();
              if (g == 1) check("gap_b2b", low_run == IFG_WORDS, low_run, IFG_WORDS);
              else check("gap_min", low_run >= IFG_WORDS, low_run, IFG_WORDS);
            end
          end
          seen_frame = 1'b1;
          low_run = 0;
          if (exp_words.size() == 0) check("word_unexpected", 1'b0, ser_word, 0);
          else begin
            w = exp_words.pop_front();
            check("word", ser_word == w, ser_word, w);
          end
          check("busy_active", busy, busy, 1);
        end else begin
          if (seen_frame && low_run < IFG_WORDS) begin
            check("ifg_word", ser_word == 8'h00, ser_word, 0);
            check("ifg_busy", busy, busy, 1);
          end else begin
            check("idle_word", ser_word == 8'h00 || ser_word == NLP_WORD, ser_word, 0);
          end
          low_run++;
        end
        if (frame_done || underrun) begin
          if (exp_evt.size() == 0) check("event_unexpected", 1'b0, {frame_done, underrun}, 0);
          else begin
            e = exp_evt.pop_front();
            check("frame_done", frame_done == (e == 0), frame_done, (e == 0));
            check("underrun", underrun == (e == 1), underrun, (e == 1));
            if (frame_done) check("done_on_etd", line_active && ser_word == 8'hFF, ser_word, 8'hFF);
          end
        end
        prev_la = line_active;
      end
    end
  end

  // Stimulus sequence.
  initial begin : stim
    int k;
    int n;
    int ab;
    int gap;
    bit b2b;
    int cyc;

    // T1: reset values and link pulse cadence.
    repeat (3) @(negedge pclk);
    check("rst_ser_word", ser_word == 8'h00, ser_word, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_tready", s_tready == 1'b0, s_tready, 0);
    check("rst_line_active", line_active == 1'b0, line_active, 0);
    check("rst_pulses", !frame_done && !underrun, {frame_done, underrun}, 0);
    aresetn = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rel_ser_word", ser_word == 8'h00, ser_word, 0);
    for (int p = 0; p < 2; p++) begin
      k = 0;
      do begin
        @(posedge pclk); #1;
        k++;
      end while (ser_word != NLP_WORD && k < NLP_PERIOD + 5);
      check("nlp_period", k == NLP_PERIOD, k, NLP_PERIOD);
    end
    idle(3);

    // T2: four-byte frame.
    frm = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(4, 0, 1'b0);
    idle(12);

    // T3: single-byte frame.
    frm = '{8'h0F};
    send_frame(1, 0, 1'b0);
    idle(15);

    // T4: underrun after two of four bytes.
    frm = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(4, 2, 1'b0);
    idle(10);

    // T5: back-to-back frames with s_tvalid held.
    frm = '{8'h01, 8'h80, 8'h7E};
    send_frame(3, 0, 1'b0);
    frm = '{8'hF0, 8'h5A};
    send_frame(2, 0, 1'b1);

    // Randomized frames, lengths, aborts and spacing.
    b2b = 1'b1;
    for (int r = 0; r < 30; r++) begin
      n = int'($urandom_range(1, 8));
      ab = 0;
      if (n >= 2 && $urandom_range(0, 4) == 0) ab = int'($urandom_range(1, n - 1));
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      send_frame(n, ab, b2b);
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
      if (gap > 0) idle(gap);
      b2b = (gap == 0);
    end
    drain();
    idle(4);

    // T6: reset while payload is streaming.
    chk_en = 1'b0;
    s_tdata = 8'h3C;
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (!line_active && cyc < 200);
    repeat (2 * PRE_BYTES + 2 + 5) @(negedge pclk);
    check("t6_active_before", line_active, line_active, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_ser_word", ser_word == 8'h00, ser_word, 0);
    check("t6_line_active", line_active == 1'b0, line_active, 0);
    check("t6_busy", busy == 1'b0, busy, 0);
    s_tvalid = 1'b0;
    exp_words.delete();
    exp_evt.delete();
    exp_gap.delete();
    frames_since_reset = 0;
    @(negedge pclk);
    aresetn = 1'b1;
    chk_en = 1'b1;
    idle(5);
    frm = '{8'hC3, 8'h99, 8'h00};
    send_frame(3, 0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
